mem_arbiter: RTL and testbench

Shared memory-port controller for the multicycle `riscv` core. It accepts instruction-fetch and data load/store requests, arbitrates between them, and decodes each address to the instruction ROM, the data RAM or the GPIO register. It sits between the core and the `imc` memories and replaces the current path in which data loads and stores land in ROM. It sequences one access at a time through a three-state FSM.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared memory-port controller: arbitrates fetch and data requests, decodes the
// address to ROM, RAM or the GPIO register, and runs one access at a time.
module mem_arbiter #(
   parameter int          ROM_WORDS = 1024,
   parameter int          RAM_WORDS = 1024,
   parameter logic [31:0] RAM_BASE  = 32'h0000_1000,
   parameter logic [31:0] GPIO_ADDR = 32'h0000_2000,
   localparam int         ROM_AW    = $clog2(ROM_WORDS),
   localparam int         RAM_AW    = $clog2(RAM_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic              d_err,
   output logic [31:0]       d_rdata,
   output logic              rom_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_rdata,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic [7:0]        gpio,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_e;
   typedef enum logic [1:0] {T_ROM = 2'd0, T_RAM = 2'd1, T_GPIO = 2'd2, T_FAULT = 2'd3} tgt_e;

   localparam logic [31:0] ROM_END = 32'(ROM_WORDS * 4);
   localparam logic [31:0] RAM_END = RAM_BASE + 32'(RAM_WORDS * 4);

   state_e              state_q, state_d;
   logic                last_data_q;
   logic                id_data_q;
   logic                we_q;
   logic [31:0]         wdata_q;
   logic [3:0]          be_q;
   tgt_e                tgt_q;
   logic [ROM_AW-1:0]   rom_idx_q;
   logic [RAM_AW-1:0]   ram_idx_q;
   logic [7:0]          gpio_q;

   logic                pick_data;
   logic                req_ok;
   logic                accept;
   logic [31:0]         sel_addr;
   logic                sel_we;
   tgt_e                sel_tgt;
   logic [31:0]         resp_data;

   // Handshake: a requester holds req with stable address; gnt is combinational,
   // only in IDLE, and the request is taken at the edge where req & gnt are high.
   always_comb begin
      pick_data = d_req && (!if_req || !last_data_q);
      req_ok    = (d_req || if_req) && !rst && (state_q == S_IDLE);
      d_gnt     = req_ok && pick_data;
      if_gnt    = req_ok && !pick_data;
      accept    = d_gnt || if_gnt;
      sel_addr  = pick_data ? d_addr : if_addr;
      sel_we    = pick_data && d_we;
   end

   always_comb begin
      sel_tgt = T_FAULT;
      if (sel_addr[1:0] == 2'b00) begin
         if (sel_addr < ROM_END)
            sel_tgt = sel_we ? T_FAULT : T_ROM;
         else if (sel_addr >= RAM_BASE && sel_addr < RAM_END)
            sel_tgt = T_RAM;
         else if (sel_addr == GPIO_ADDR)
            sel_tgt = pick_data ? T_GPIO : T_FAULT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_ACCESS;
         S_ACCESS: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // RAM index subtracts only the word bits; valid RAM hits are word aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_data_q <= 1'b0;
         id_data_q   <= 1'b0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         be_q        <= '0;
         tgt_q       <= T_FAULT;
         rom_idx_q   <= '0;
         ram_idx_q   <= '0;
         gpio_q      <= '0;
      end else begin
         if (accept) begin
            last_data_q <= d_gnt;
            id_data_q   <= d_gnt;
            we_q        <= sel_we;
            wdata_q     <= d_wdata;
            be_q        <= d_be;
            tgt_q       <= sel_tgt;
            rom_idx_q   <= sel_addr[ROM_AW+1:2];
            ram_idx_q   <= sel_addr[RAM_AW+1:2] - RAM_BASE[RAM_AW+1:2];
         end
         if (state_q == S_ACCESS && tgt_q == T_GPIO && we_q && be_q[0])
            gpio_q <= wdata_q[7:0];
      end
   end

   always_comb begin
      rom_en    = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 4'b0;
      rom_addr  = rom_idx_q;
      ram_addr  = ram_idx_q;
      ram_wdata = wdata_q;
      if_rvalid = 1'b0;
      if_err    = 1'b0;
      if_rdata  = '0;
      d_rvalid  = 1'b0;
      d_err     = 1'b0;
      d_rdata   = '0;
      resp_data = '0;
      if (!rst && state_q == S_ACCESS) begin
         rom_en = (tgt_q == T_ROM);
         ram_en = (tgt_q == T_RAM);
         ram_we = (tgt_q == T_RAM && we_q) ? be_q : 4'b0;
      end
      if (!rst && state_q == S_RESP) begin
         case (tgt_q)
            T_ROM:   resp_data = rom_rdata;
            T_RAM:   resp_data = we_q ? 32'h0 : ram_rdata;
            T_GPIO:  resp_data = we_q ? 32'h0 : {24'h0, gpio_q};
            default: resp_data = 32'h0;
         endcase
         if (id_data_q) begin
            d_rvalid = 1'b1;
            d_err    = (tgt_q == T_FAULT);
            d_rdata  = resp_data;
         end else begin
            if_rvalid = 1'b1;
            if_err    = (tgt_q == T_FAULT);
            if_rdata  = resp_data;
         end
      end
   end

   assign gpio      = gpio_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural ROM/RAM, per-scenario tasks and an
// expected-response queue holding {is_data, err, rdata}.
module tb_mem_arbiter;
   localparam int EW = 34;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_gnt, if_rvalid, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
   logic        rom_en, ram_en;
   logic [9:0]  rom_addr, ram_addr;
   logic [31:0] rom_rdata, ram_rdata, ram_wdata;
   logic [3:0]  ram_we;
   logic [7:0]  gpio;
   logic [1:0]  state_dbg;

   logic [31:0]   rom_mem [0:1023];
   logic [31:0]   ram_mem [0:1023];
   logic [EW-1:0] exp_q[$];
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .gpio(gpio), .state_dbg(state_dbg)
   );

   always @(posedge clk) begin
      if (rom_en) rom_rdata <= rom_mem[rom_addr];
      if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= ram_mem[ram_addr];
      end
   end

   function automatic logic [EW-1:0] obs_resp(input bit is_data);
      return is_data ? {1'b1, d_err, d_rdata} : {1'b0, if_err, if_rdata};
   endfunction

   // Returns at the negedge inside ACCESS with the request already dropped.
   task automatic drive_req(input bit is_data, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      if (is_data) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      for (int i = 0; i < 8 && !ok; i++) begin
         #1;
         if ((is_data && d_gnt) || (!is_data && if_gnt)) begin
            ok = 1'b1;
            @(posedge clk);
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      d_req  = 1'b0;
      if_req = 1'b0;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         total++;
         if ({if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, rom_en, ram_en, ram_we} !== 12'h0 ||
             gpio !== 8'h0 || if_rdata !== 32'h0 || d_rdata !== 32'h0 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL reset_outputs cyc=%0d gnt=%b%b rv=%b%b en=%b%b we=%h gpio=%h state=%0d exp all zero",
                     c, if_gnt, d_gnt, if_rvalid, d_rvalid, rom_en, ram_en, ram_we, gpio, state_dbg);
         end
      end
      rst = 1'b0;
      #1;
      total++;
      if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
         bad++;
         $display("FAIL reset_first_gnt got d=%b if=%b exp d=1 if=0", d_gnt, if_gnt);
      end
      d_req  = 1'b0;
      if_req = 1'b0;
   endtask

   task automatic test_fetch();
      bit ok;
      logic [EW-1:0] exp;
      exp_q.push_back({1'b0, 1'b0, 32'h000f_1137});
      drive_req(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL fetch_gnt got none exp if_gnt"); end
      total++;
      if (rom_en !== 1'b1 || rom_addr !== 10'd1 || ram_en !== 1'b0 || if_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL fetch_access got rom_en=%b rom_addr=%0d ram_en=%b rv=%b exp 1 1 0 0",
                  rom_en, rom_addr, ram_en, if_rvalid);
      end
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || obs_resp(1'b0) !== exp) begin
         bad++;
         $display("FAIL fetch_resp got rv=%b resp=%h exp rv=1 resp=%h", if_rvalid, obs_resp(1'b0), exp);
      end
   endtask

   task automatic test_store_load();
      bit ok;
      logic [EW-1:0] exp;
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      drive_req(1'b1, 1'b1, 32'h1000, 32'h0001_f000, 4'hF, ok);
      total++;
      if (!ok || ram_en !== 1'b1 || ram_we !== 4'hF || ram_addr !== 10'd0 ||
          ram_wdata !== 32'h0001_f000 || rom_en !== 1'b0) begin
         bad++;
         $display("FAIL store_access got ok=%b en=%b we=%h addr=%0d wdata=%h exp 1 1 f 0 0001f000",
                  ok, ram_en, ram_we, ram_addr, ram_wdata);
      end
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if (d_rvalid !== 1'b1 || obs_resp(1'b1) !== exp) begin
         bad++;
         $display("FAIL store_resp got rv=%b resp=%h exp rv=1 resp=%h", d_rvalid, obs_resp(1'b1), exp);
      end
      exp_q.push_back({1'b1, 1'b0, 32'h0001_f000});
      drive_req(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, ok);
      total++;
      if (!ok || ram_en !== 1'b1 || ram_we !== 4'h0) begin
         bad++;
         $display("FAIL load_access got ok=%b en=%b we=%h exp 1 1 0", ok, ram_en, ram_we);
      end
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if (d_rvalid !== 1'b1 || obs_resp(1'b1) !== exp) begin
         bad++;
         $display("FAIL load_resp got rv=%b resp=%h exp rv=1 resp=%h", d_rvalid, obs_resp(1'b1), exp);
      end
      exp_q.push_back({1'b0, 1'b0, 32'h0000_0013});
      drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ok);
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if (!ok || if_rvalid !== 1'b1 || obs_resp(1'b0) !== exp) begin
         bad++;
         $display("FAIL rom0_intact got ok=%b rv=%b resp=%h exp rv=1 resp=%h",
                  ok, if_rvalid, obs_resp(1'b0), exp);
      end
   endtask

   // Last grant was a fetch, so the tie starts with data and then alternates.
   task automatic test_tie();
      int ngrant = 0;
      int last_c = 0;
      bit dropped = 1'b0;
      bit want_data;
      logic [EW-1:0] exp;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000; d_wdata = 32'h0; d_be = 4'h0;
      if_req = 1'b1; if_addr = 32'h8;
      for (int c = 0; c < 40 && !(dropped && exp_q.size() == 0); c++) begin
         #1;
         if (d_gnt || if_gnt) begin
            want_data = (ngrant % 2 == 0);
            total++;
            if (d_gnt !== want_data || if_gnt !== !want_data || (ngrant > 0 && c - last_c != 3)) begin
               bad++;
               $display("FAIL tie_order n=%0d got d=%b if=%b gap=%0d exp d=%b gap=3",
                        ngrant, d_gnt, if_gnt, c - last_c, want_data);
            end
            if (d_gnt) exp_q.push_back({1'b1, 1'b0, 32'h0001_f000});
            else       exp_q.push_back({1'b0, 1'b0, 32'h0020_0093});
            last_c = c;
            ngrant++;
         end
         if (d_rvalid || if_rvalid) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL tie_resp got unexpected rvalid d=%b if=%b exp none", d_rvalid, if_rvalid);
            end else begin
               exp = exp_q.pop_front();
               if (obs_resp(d_rvalid) !== exp || (d_rvalid && if_rvalid)) begin
                  bad++;
                  $display("FAIL tie_resp got %h exp %h", obs_resp(d_rvalid), exp);
               end
            end
         end
         @(negedge clk);
         if (ngrant == 4 && !dropped) begin
            d_req = 1'b0; if_req = 1'b0; dropped = 1'b1;
         end
      end
      d_req = 1'b0; if_req = 1'b0;
      total++;
      if (ngrant != 4 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL tie_count got grants=%0d pending=%0d exp 4 0", ngrant, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_faults();
      bit          fd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      bit          fw [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] fa [4] = '{32'h0, 32'h1002, 32'h3000, 32'h2000};
      bit ok;
      logic [EW-1:0] exp;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({fd[k], 1'b1, 32'h0});
         drive_req(fd[k], fw[k], fa[k], 32'hFFFF_FFFF, 4'hF, ok);
         total++;
         if (!ok || rom_en !== 1'b0 || ram_en !== 1'b0 || ram_we !== 4'h0) begin
            bad++;
            $display("FAIL fault_strobe addr=%h got ok=%b rom_en=%b ram_en=%b we=%h exp 1 0 0 0",
                     fa[k], ok, rom_en, ram_en, ram_we);
         end
         @(negedge clk);
         exp = exp_q.pop_front();
         total++;
         if ((fd[k] ? d_rvalid : if_rvalid) !== 1'b1 || obs_resp(fd[k]) !== exp || gpio !== 8'h0) begin
            bad++;
            $display("FAIL fault_resp addr=%h got resp=%h gpio=%h exp resp=%h gpio=00",
                     fa[k], obs_resp(fd[k]), gpio, exp);
         end
      end
   endtask

   task automatic test_gpio_reset_mid();
      bit ok;
      logic [EW-1:0] exp;
      logic [31:0] wd [3] = '{32'h0000_00A5, 32'h0000_003C, 32'h1234_5678};
      logic [31:0] wa [3] = '{32'h2000, 32'h2000, 32'h1010};
      logic [3:0]  wb [3] = '{4'hF, 4'hE, 4'hF};
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back({1'b1, 1'b0, 32'h0});
         drive_req(1'b1, 1'b1, wa[k], wd[k], wb[k], ok);
         @(negedge clk);
         exp = exp_q.pop_front();
         total++;
         if (!ok || d_rvalid !== 1'b1 || obs_resp(1'b1) !== exp || gpio !== 8'hA5) begin
            bad++;
            $display("FAIL gpio_write k=%0d got ok=%b rv=%b resp=%h gpio=%h exp rv=1 resp=%h gpio=a5",
                     k, ok, d_rvalid, obs_resp(1'b1), gpio, exp);
         end
      end
      exp_q.push_back({1'b1, 1'b0, 32'h0000_00A5});
      drive_req(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, ok);
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if (!ok || d_rvalid !== 1'b1 || obs_resp(1'b1) !== exp) begin
         bad++;
         $display("FAIL gpio_read got rv=%b resp=%h exp %h", d_rvalid, obs_resp(1'b1), exp);
      end
      drive_req(1'b1, 1'b1, 32'h1010, 32'hDEAD_BEEF, 4'hF, ok);
      rst = 1'b1;
      #1;
      total++;
      if (!ok || ram_en !== 1'b0 || ram_we !== 4'h0) begin
         bad++;
         $display("FAIL midrst_strobe got ok=%b en=%b we=%h exp 1 0 0", ok, ram_en, ram_we);
      end
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (d_rvalid !== 1'b0 || ram_mem[4] !== 32'h1234_5678 || gpio !== 8'h0) begin
         bad++;
         $display("FAIL midrst_state got rv=%b ram4=%h gpio=%h exp 0 12345678 00", d_rvalid, ram_mem[4], gpio);
      end
      @(negedge clk);
      total++;
      if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || state_dbg !== 2'd0) begin
         bad++;
         $display("FAIL midrst_norv got rv=%b%b state=%0d exp 00 0", d_rvalid, if_rvalid, state_dbg);
      end
      exp_q.push_back({1'b1, 1'b0, 32'h1234_5678});
      drive_req(1'b1, 1'b0, 32'h1010, 32'h0, 4'h0, ok);
      @(negedge clk);
      exp = exp_q.pop_front();
      total++;
      if (!ok || d_rvalid !== 1'b1 || obs_resp(1'b1) !== exp) begin
         bad++;
         $display("FAIL midrst_readback got rv=%b resp=%h exp %h", d_rvalid, obs_resp(1'b1), exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom_range(32'hFFFF, 32'h100);
      rom_mem[0] = 32'h0000_0013;
      rom_mem[1] = 32'h000f_1137;
      rom_mem[2] = 32'h0020_0093;
      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h4;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000; d_wdata = 32'h0; d_be = 4'h0;
      test_reset();
      test_fetch();
      test_store_load();
      test_tie();
      test_faults();
      test_gpio_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
